branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default core_pkg::XLEN (32), datapath width.
REQ-002 SHALL have parameter RECOVER_CYCLES, default 2, input-block cycles after a redirect (range 1-15).
REQ-003 SHALL have parameter TAG_W, default 6, ROB tag width.
REQ-004 clk  input  1  clock; all state rises on posedge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  pipeline flush from commit; kills all in-flight work.
REQ-007 in_valid / in_ready  input / output  1 / 1  branch-op handshake.
REQ-008 in_pc, in_imm, in_rs  input  XLEN each  branch PC, byte offset (pre-shifted, sign-extended), register operand.
REQ-009 in_op  input  3  0=B, 1=BL, 2=BR, 3=CBZ, 4=CBNZ, 5=BCOND; 6-7 illegal.
REQ-010 in_cond, in_nzcv  input  4 / 4  B.cond condition code and flags.
REQ-011 in_pred_taken, in_pred_target, in_rob_tag  input  1 / XLEN / TAG_W  fetch prediction and ROB tag.
REQ-012 update_en, update_pc, update_taken, update_target, update_is_branch, update_is_call, update_is_return  output  1/XLEN/1/XLEN/1/1/1  predictor training port.
REQ-013 redirect_valid, redirect_pc  output  1 / XLEN  frontend redirect.
REQ-014 done_valid, done_rob_tag, done_link_valid, done_link_value  output  1/TAG_W/1/XLEN  completion to ROB.
REQ-015 stat_branches, stat_mispredicts  output  32 each  resolved-op and mispredict counters.

Function
REQ-016 Pipeline: S1 captures the op on an in_valid&&in_ready edge; S1 evaluates combinationally; S2 registers results; all outputs come from S2; latency is 2 edges, handshake edge k -> outputs valid in the cycle after edge k+1.
REQ-017 Taken: B/BL/BR=1; CBZ = (rs==0); CBNZ = (rs!=0); BCOND uses the ARM cond table on NZCV (EQ..LE, AL=1, NV=1).
REQ-018 Target: BR=rs; all others pc+imm, modulo 2^XLEN. Fall-through is pc+4, wrapping.
REQ-019 actual_next = taken ? target : pc+4; pred_next = pred_taken ? pred_target : pc+4; mispredict = (actual_next != pred_next).
REQ-020 Each resolved op pulses update_en, update_pc=pc, update_taken, update_target=target (even when not taken), is_branch for CBZ/CBNZ/BCOND, is_call for BL, and is_return for BR, all for exactly 1 cycle.
REQ-021 done_valid pulses 1 cycle per resolved op with its tag; link_valid=1 and link_value=pc+4 only for BL.
REQ-022 On mispredict, redirect_valid pulses 1 cycle with redirect_pc=actual_next, in the same cycle as update_en.
REQ-023 FSM states: IDLE and RECOVER. Mispredict in S1 -> RECOVER at that edge, with a counter loaded to RECOVER_CYCLES; it decrements each cycle and returns to IDLE when it reaches 0.
REQ-024 in_ready = state==IDLE && !(S1 valid && S1 mispredict) && !flush; a wrong-path op is never accepted behind a mispredict.
REQ-025 No output backpressure; back-to-back correct-predicted ops sustain 1 op/cycle.
REQ-026 flush: S1/S2 valid cleared at the edge; all output pulses gated low combinationally during the flush cycle; FSM goes to IDLE and the counter to 0; flush outranks a coincident mispredict.
REQ-027 Illegal in_op: treated as not-taken, update_en suppressed, done_valid still pulses, and no redirect unless pred_taken (then redirect to pc+4).
REQ-028 stat_branches increments per done_valid; stat_mispredicts increments per redirect_valid; both wrap at 2^32.

Reset
REQ-029 Reset clears S1/S2 valid, FSM=IDLE, counter=0, stats=0, and drives all outputs 0; in_ready=0 while reset is high.
REQ-030 Reset mid-operation discards in-flight ops with no output pulse; in_ready returns to 1 on the first cycle after deassert.

Verification
REQ-031 CBZ pc=0x100, rs=0, imm=0x40, pred_taken=1, target=0x140 -> 2 cycles later update_en, taken=1, is_branch=1, no redirect.
REQ-032 BCOND EQ, NZCV=0000, pc=0x200, pred_taken=1 to 0x280 -> redirect_pc=0x204; in_ready low for 1 (S1) + RECOVER_CYCLES cycles; stat_mispredicts=1.
REQ-033 BL pc=0x300, imm=0x100 then BR rs=0x304, both predicted correctly -> is_call then is_return pulses; link_value=0x304 only on BL.
REQ-034 Ten back-to-back correctly predicted B ops -> ten consecutive done_valid cycles, in_ready stays high, stat_branches=10.
REQ-035 Mispredicting op in S2 with flush in the same cycle -> no redirect, no update_en, FSM IDLE next cycle.
REQ-036 pc=0xFFFFFFFC, CBNZ rs=0, pred_taken=1 -> redirect_pc=0x00000000 (wrap).

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: evaluates branch ops in S1, registers results in S2,
// drives predictor training, frontend redirect and ROB completion from S2.
module branch_resolve_unit #(
  parameter int XLEN           = 32,
  parameter int RECOVER_CYCLES = 2,
  parameter int TAG_W          = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_rs,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_cond,
  input  logic [3:0]       in_nzcv,
  input  logic             in_pred_taken,
  input  logic [XLEN-1:0]  in_pred_target,
  input  logic [TAG_W-1:0] in_rob_tag,
  output logic             update_en,
  output logic [XLEN-1:0]  update_pc,
  output logic             update_taken,
  output logic [XLEN-1:0]  update_target,
  output logic             update_is_branch,
  output logic             update_is_call,
  output logic             update_is_return,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             done_valid,
  output logic [TAG_W-1:0] done_rob_tag,
  output logic             done_link_valid,
  output logic [XLEN-1:0]  done_link_value,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
);

  localparam int CNT_W = 4;
  localparam logic [2:0] OP_B     = 3'd0;
  localparam logic [2:0] OP_BL    = 3'd1;
  localparam logic [2:0] OP_BR    = 3'd2;
  localparam logic [2:0] OP_CBZ   = 3'd3;
  localparam logic [2:0] OP_CBNZ  = 3'd4;
  localparam logic [2:0] OP_BCOND = 3'd5;

  typedef enum logic {IDLE, RECOVER} state_t;

  // ARM condition table: cond[3:1] selects the base test, cond[0] inverts it
  // except for 4'b1111 (NV), which behaves as always.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, base;
    {n, z, c, v} = nzcv;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (cond[0] && (cond != 4'hF)) ? ~base : base;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s1_valid_q, s2_valid_q;
  logic [31:0]        stat_br_q, stat_mp_q;

  logic [XLEN-1:0]    s1_pc_q, s1_imm_q, s1_rs_q, s1_ptgt_q;
  logic [2:0]         s1_op_q;
  logic [3:0]         s1_cond_q, s1_nzcv_q;
  logic               s1_pt_q;
  logic [TAG_W-1:0]   s1_tag_q;

  logic               s1_legal, s1_taken, s1_mispredict, s1_mp_fire, accept;
  logic [XLEN-1:0]    s1_fall, s1_target, s1_actual, s1_pred;

  logic               s2_legal_q, s2_mp_q, s2_taken_q, s2_is_br_q, s2_is_call_q;
  logic               s2_is_ret_q, s2_link_q;
  logic [XLEN-1:0]    s2_pc_q, s2_target_q, s2_rpc_q, s2_link_val_q;
  logic [TAG_W-1:0]   s2_tag_q;
  logic               s2_fire;

  // S1: combinational resolution of the captured op
  always_comb begin
    s1_legal  = (s1_op_q <= OP_BCOND);
    s1_fall   = s1_pc_q + XLEN'(4);
    s1_target = (s1_op_q == OP_BR) ? s1_rs_q : s1_pc_q + s1_imm_q;
    case (s1_op_q)
      OP_B, OP_BL, OP_BR: s1_taken = 1'b1;
      OP_CBZ:             s1_taken = (s1_rs_q == '0);
      OP_CBNZ:            s1_taken = (s1_rs_q != '0);
      OP_BCOND:           s1_taken = cond_pass(s1_cond_q, s1_nzcv_q);
      default:            s1_taken = 1'b0;
    endcase
    s1_actual     = s1_taken ? s1_target : s1_fall;
    s1_pred       = s1_pt_q ? s1_ptgt_q : s1_fall;
    s1_mispredict = s1_legal ? (s1_actual != s1_pred) : s1_pt_q;
  end

  assign s1_mp_fire = s1_valid_q && s1_mispredict;
  assign in_ready   = !reset && (state_q == IDLE) && !s1_mp_fire && !flush;
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (s1_mp_fire) begin
      state_d = RECOVER;
      cnt_d   = CNT_W'(RECOVER_CYCLES);
    end else if (state_q == RECOVER) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q <= CNT_W'(1)) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      stat_br_q  <= '0;
      stat_mp_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q && !flush;
      if (done_valid)     stat_br_q <= stat_br_q + 32'd1;
      if (redirect_valid) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_pc_q   <= in_pc;
      s1_imm_q  <= in_imm;
      s1_rs_q   <= in_rs;
      s1_op_q   <= in_op;
      s1_cond_q <= in_cond;
      s1_nzcv_q <= in_nzcv;
      s1_pt_q   <= in_pred_taken;
      s1_ptgt_q <= in_pred_target;
      s1_tag_q  <= in_rob_tag;
    end
    // S1 -> S2 result register
    if (s1_valid_q) begin
      s2_legal_q    <= s1_legal;
      s2_mp_q       <= s1_mispredict;
      s2_taken_q    <= s1_taken;
      s2_pc_q       <= s1_pc_q;
      s2_target_q   <= s1_target;
      s2_rpc_q      <= s1_actual;
      s2_is_br_q    <= (s1_op_q == OP_CBZ) || (s1_op_q == OP_CBNZ) || (s1_op_q == OP_BCOND);
      s2_is_call_q  <= (s1_op_q == OP_BL);
      s2_is_ret_q   <= (s1_op_q == OP_BR);
      s2_link_q     <= (s1_op_q == OP_BL);
      s2_link_val_q <= s1_fall;
      s2_tag_q      <= s1_tag_q;
    end
  end

  // S2 outputs, gated low while a flush is present
  assign s2_fire          = s2_valid_q && !flush;
  assign done_valid       = s2_fire;
  assign done_rob_tag     = s2_fire ? s2_tag_q : '0;
  assign done_link_valid  = s2_fire && s2_link_q;
  assign done_link_value  = done_link_valid ? s2_link_val_q : '0;
  assign update_en        = s2_fire && s2_legal_q;
  assign update_pc        = update_en ? s2_pc_q : '0;
  assign update_taken     = update_en && s2_taken_q;
  assign update_target    = update_en ? s2_target_q : '0;
  assign update_is_branch = update_en && s2_is_br_q;
  assign update_is_call   = update_en && s2_is_call_q;
  assign update_is_return = update_en && s2_is_ret_q;
  assign redirect_valid   = s2_fire && s2_mp_q;
  assign redirect_pc      = redirect_valid ? s2_rpc_q : '0;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against a cycle-timeline
// reference model (results due two edges after acceptance, blocking windows).
module tb_branch_resolve_unit;
  localparam int XLEN = 32;
  localparam int R    = 2;
  localparam int TW   = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_pc = '0, in_imm = '0, in_rs = '0, in_pred_target = '0;
  logic [2:0]      in_op = '0;
  logic [3:0]      in_cond = '0, in_nzcv = '0;
  logic            in_pred_taken = 1'b0;
  logic [TW-1:0]   in_rob_tag = '0;
  logic            update_en, update_taken, update_is_branch, update_is_call, update_is_return;
  logic [31:0]     update_pc, update_target, redirect_pc, done_link_value;
  logic            redirect_valid, done_valid, done_link_valid;
  logic [TW-1:0]   done_rob_tag;
  logic [31:0]     stat_branches, stat_mispredicts;

  branch_resolve_unit #(.XLEN(XLEN), .RECOVER_CYCLES(R), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs(in_rs), .in_op(in_op),
    .in_cond(in_cond), .in_nzcv(in_nzcv),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_rob_tag(in_rob_tag),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_is_branch(update_is_branch),
    .update_is_call(update_is_call), .update_is_return(update_is_return),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .done_valid(done_valid), .done_rob_tag(done_rob_tag),
    .done_link_valid(done_link_valid), .done_link_value(done_link_value),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [2:0] op; logic [31:0] pc, imm, rs; logic [3:0] cond, nzcv;
    logic pt; logic [31:0] ptgt; logic [TW-1:0] tag; logic fl;
  } in_t;

  typedef struct {
    int due; logic legal, taken, mp, is_br, is_call, is_ret, link_v;
    logic [31:0] pc, target, rpc, link; logic [TW-1:0] tag;
  } rec_t;

  rec_t  q[$];
  in_t   prev;
  logic  prev_ready = 1'b0;
  int    cyc = 0, block_end = -1, exp_br = 0, exp_mp = 0;
  int    n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic rec_t model(input in_t x);
    rec_t r;
    logic [31:0] fall, pred;
    fall = x.pc + 32'd4;
    r.due = 0;
    r.legal = (x.op < 3'd6);
    case (x.op)
      3'd0, 3'd1, 3'd2: r.taken = 1'b1;
      3'd3: r.taken = (x.rs == 32'd0);
      3'd4: r.taken = (x.rs != 32'd0);
      3'd5: r.taken = cond_holds(x.cond, x.nzcv);
      default: r.taken = 1'b0;
    endcase
    r.target = (x.op == 3'd2) ? x.rs : x.pc + x.imm;
    r.rpc    = r.taken ? r.target : fall;
    pred     = x.pt ? x.ptgt : fall;
    r.mp     = r.legal ? (r.rpc != pred) : x.pt;
    r.pc     = x.pc;
    r.is_br  = (x.op == 3'd3) || (x.op == 3'd4) || (x.op == 3'd5);
    r.is_call = (x.op == 3'd1);
    r.is_ret = (x.op == 3'd2);
    r.link_v = (x.op == 3'd1);
    r.link   = r.link_v ? fall : 32'd0;
    r.tag    = x.tag;
    return r;
  endfunction

  function automatic in_t idle_in();
    in_t x;
    x.v = 0; x.op = 0; x.pc = 0; x.imm = 0; x.rs = 0; x.cond = 0; x.nzcv = 0;
    x.pt = 0; x.ptgt = 0; x.tag = 0; x.fl = 0;
    return x;
  endfunction

  function automatic in_t mk(input logic [2:0] op, input logic [31:0] pc, imm, rs,
                             input logic [3:0] cond, nzcv, input logic pt,
                             input logic [31:0] ptgt, input logic [TW-1:0] tag);
    in_t x;
    x.v = 1; x.op = op; x.pc = pc; x.imm = imm; x.rs = rs; x.cond = cond; x.nzcv = nzcv;
    x.pt = pt; x.ptgt = ptgt; x.tag = tag; x.fl = 0;
    return x;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    rec_t r;
    x.v    = ($urandom_range(0, 9) < 7);
    x.op   = ($urandom_range(0, 19) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
    x.pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
    x.imm  = $urandom;
    x.rs   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    x.cond = 4'($urandom);
    x.nzcv = 4'($urandom);
    x.tag  = TW'($urandom);
    x.fl   = ($urandom_range(0, 39) == 0);
    x.pt   = 0;
    x.ptgt = 0;
    r = model(x);
    if ($urandom_range(0, 3) != 0) begin
      x.pt   = r.taken;
      x.ptgt = r.taken ? r.target : $urandom;
    end else begin
      x.pt   = 1'($urandom);
      x.ptgt = ($urandom_range(0, 1) == 1) ? r.target : $urandom;
    end
    return x;
  endfunction

  task automatic drive(input in_t x);
    in_valid = x.v; in_op = x.op; in_pc = x.pc; in_imm = x.imm; in_rs = x.rs;
    in_cond = x.cond; in_nzcv = x.nzcv; in_pred_taken = x.pt;
    in_pred_target = x.ptgt; in_rob_tag = x.tag; flush = x.fl;
  endtask

  // One clock cycle: account acceptance at the edge, drive, then check outputs.
  task automatic step(input in_t x);
    rec_t r, o;
    logic acc_mp, has, er;
    @(posedge clk);
    cyc++;
    acc_mp = 1'b0;
    if (prev.v && prev_ready) begin
      r = model(prev);
      r.due = cyc + 1;
      q.push_back(r);
      acc_mp = r.mp;
    end
    #1 drive(x);
    if (x.fl) begin
      q.delete();
      block_end = cyc;
    end else if (acc_mp) begin
      block_end = cyc + R;
    end
    er = !x.fl && (cyc > block_end);
    @(negedge clk);
    has = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      o = q.pop_front();
      has = 1'b1;
    end
    check("in_ready", 32'(in_ready), 32'(er));
    check("done_valid", 32'(done_valid), 32'(has));
    check("update_en", 32'(update_en), 32'(has && o.legal));
    check("redirect_valid", 32'(redirect_valid), 32'(has && o.mp));
    if (has) begin
      check("done_rob_tag", 32'(done_rob_tag), 32'(o.tag));
      check("done_link_valid", 32'(done_link_valid), 32'(o.link_v));
      check("done_link_value", done_link_value, o.link);
      if (o.legal) begin
        check("update_pc", update_pc, o.pc);
        check("update_taken", 32'(update_taken), 32'(o.taken));
        check("update_target", update_target, o.target);
        check("update_is_branch", 32'(update_is_branch), 32'(o.is_br));
        check("update_is_call", 32'(update_is_call), 32'(o.is_call));
        check("update_is_return", 32'(update_is_return), 32'(o.is_ret));
      end
      if (o.mp) check("redirect_pc", redirect_pc, o.rpc);
    end
    check("stat_branches", stat_branches, 32'(exp_br));
    check("stat_mispredicts", stat_mispredicts, 32'(exp_mp));
    if (has) begin
      exp_br++;
      if (o.mp) exp_mp++;
    end
    prev = x;
    prev_ready = er;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    cyc++;
    #1 reset = 1'b1;
    drive(idle_in());
    q.delete();
    block_end = -1; exp_br = 0; exp_mp = 0;
    prev = idle_in(); prev_ready = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_done_valid", 32'(done_valid), 32'd0);
      check("rst_update_en", 32'(update_en), 32'd0);
      check("rst_redirect", 32'(redirect_valid), 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_stat_br", stat_branches, 32'd0);
      check("rst_stat_mp", stat_mispredicts, 32'd0);
      @(posedge clk);
      cyc++;
    end
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(in_ready), 32'd1);
    check("rst_release_done", 32'(done_valid), 32'd0);
    prev_ready = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(idle_in());
  endtask

  initial begin
    in_t x;
    prev = idle_in();
    do_reset(2);

    // CBZ taken, predicted correctly
    step(mk(3'd3, 32'h100, 32'h40, 32'h0, 4'd0, 4'd0, 1'b1, 32'h140, 6'd1));
    idle(3);

    // B.EQ not taken but predicted taken: redirect to fall-through, input blocked
    do_reset(1);
    step(mk(3'd5, 32'h200, 32'h80, 32'h0, 4'd0, 4'b0000, 1'b1, 32'h280, 6'd2));
    for (int i = 0; i < 6; i++)
      step(mk(3'd0, 32'h1000 + 32'(i * 4), 32'h20, 32'h0, 4'd0, 4'd0, 1'b1, 32'h1020 + 32'(i * 4), 6'(i)));
    idle(3);
    check("req32_stat_mp", stat_mispredicts, 32'd1);

    // BL then BR return
    step(mk(3'd1, 32'h300, 32'h100, 32'h0, 4'd0, 4'd0, 1'b1, 32'h400, 6'd3));
    step(mk(3'd2, 32'h400, 32'h0, 32'h304, 4'd0, 4'd0, 1'b1, 32'h304, 6'd4));
    idle(3);

    // ten back-to-back correctly predicted B ops
    do_reset(1);
    for (int i = 0; i < 10; i++)
      step(mk(3'd0, 32'h2000 + 32'(i * 4), 32'h40, 32'h0, 4'd0, 4'd0, 1'b1, 32'h2040 + 32'(i * 4), 6'(i)));
    idle(3);
    check("req34_stat_br", stat_branches, 32'd10);

    // mispredict reaching S2 together with a flush
    step(mk(3'd4, 32'h500, 32'h10, 32'h0, 4'd0, 4'd0, 1'b1, 32'h510, 6'd5));
    step(idle_in());
    x = idle_in(); x.fl = 1'b1;
    step(x);
    idle(2);

    // CBNZ not taken at top of address space: fall-through wraps to zero
    step(mk(3'd4, 32'hFFFF_FFFC, 32'h40, 32'h0, 4'd0, 4'd0, 1'b1, 32'h1234, 6'd6));
    idle(5);

    // illegal ops, with and without a taken prediction
    step(mk(3'd6, 32'h600, 32'h40, 32'h0, 4'd0, 4'd0, 1'b1, 32'h640, 6'd7));
    idle(4);
    step(mk(3'd7, 32'h700, 32'h40, 32'h0, 4'd0, 4'd0, 1'b0, 32'h0, 6'd8));
    idle(3);

    // reset with an op in flight
    step(mk(3'd0, 32'h800, 32'h40, 32'h0, 4'd0, 4'd0, 1'b1, 32'h840, 6'd9));
    step(idle_in());
    do_reset(1);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 4000; i++) step(rand_in());
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
